// File: rtl/gray_frame_sequencer.sv
// In-place RGB888 -> grayscale conversion of a single-port frame buffer.
// One pixel every RD_LAT+2 cycles: READ, RD_LAT x WAIT, WRITE.
module gray_frame_sequencer #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [23:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [23:0]       mem_wr_data
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int                CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RD_LAT - 1);

    localparam logic [1:0] MODE_AVG = 2'd1;
    localparam logic [1:0] MODE_LUM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, w_next_addr;
    logic [CNT_W-1:0]  r_wait_cnt, w_next_cnt;
    logic [1:0]        r_mode, w_next_mode;

    logic              r_busy, r_done, r_rd_en, r_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [23:0]       r_wr_data;

    logic [9:0]        w_sum;
    logic [16:0]       w_avg_prod;
    logic [15:0]       w_lum_sum;
    logic [7:0]        w_gray;
    logic [23:0]       w_wr_word;

    always_comb begin
        w_next      = r_state;
        w_next_addr = r_addr;
        w_next_cnt  = r_wait_cnt;
        w_next_mode = r_mode;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next_mode = mode_sel;
                    w_next_addr = '0;
                    w_next      = S_READ;
                end
            end
            S_READ: begin
                w_next_cnt = WAIT_INIT;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next = S_WRITE;
                end else begin
                    w_next_cnt = r_wait_cnt - 1'b1;
                end
            end
            S_WRITE: begin
                if (r_addr == LAST_ADDR) begin
                    w_next = S_DONE;
                end else begin
                    w_next_addr = r_addr + 1'b1;
                    w_next      = S_READ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // Gray is computed straight from mem_rd_data on the last WAIT cycle and
    // registered as the write word, so the WRITE-cycle outputs stay Moore.
    always_comb begin
        w_sum      = 10'(mem_rd_data[23:16]) + 10'(mem_rd_data[15:8]) + 10'(mem_rd_data[7:0]);
        w_avg_prod = 17'(w_sum) * 17'd85;
        w_lum_sum  = 16'd54  * 16'(mem_rd_data[23:16])
                   + 16'd183 * 16'(mem_rd_data[15:8])
                   + 16'd18  * 16'(mem_rd_data[7:0]);
        w_gray     = '0;
        w_wr_word  = mem_rd_data;
        if (r_mode == MODE_AVG) begin
            w_gray    = 8'(w_avg_prod >> 8);
            w_wr_word = {w_gray, w_gray, w_gray};
        end else if (r_mode == MODE_LUM) begin
            w_gray    = 8'(w_lum_sum >> 8);
            w_wr_word = {w_gray, w_gray, w_gray};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wait_cnt <= '0;
            r_mode     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_mem_addr <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_addr     <= w_next_addr;
            r_wait_cnt <= w_next_cnt;
            r_mode     <= w_next_mode;
            r_busy     <= (w_next == S_READ) || (w_next == S_WAIT) || (w_next == S_WRITE);
            r_done     <= (w_next == S_DONE);
            r_rd_en    <= (w_next == S_READ);
            r_wr_en    <= (w_next == S_WRITE);
            r_mem_addr <= ((w_next == S_READ) || (w_next == S_WRITE)) ? w_next_addr : '0;
            r_wr_data  <= (w_next == S_WRITE) ? w_wr_word : '0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_addr    = r_mem_addr;
    assign mem_rd_en   = r_rd_en;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_data = r_wr_data;

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Directed bench: a 4x2 instance for protocol/arithmetic cases and a full
// 160x120 instance for the long luminance pass with a per-pixel scoreboard.
module tb_gray_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        s_start, s_abort, s_busy, s_done, s_rd_en, s_wr_en;
    logic [1:0]  s_mode;
    logic [2:0]  s_addr;
    logic [23:0] s_rd_data, s_wr_data;

    logic        b_start, b_abort, b_busy, b_done, b_rd_en, b_wr_en;
    logic [1:0]  b_mode;
    logic [14:0] b_addr;
    logic [23:0] b_rd_data, b_wr_data;

    gray_frame_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .RD_LAT(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .mode_sel(s_mode),
        .busy(s_busy), .done(s_done), .mem_addr(s_addr), .mem_rd_en(s_rd_en),
        .mem_rd_data(s_rd_data), .mem_wr_en(s_wr_en), .mem_wr_data(s_wr_data)
    );

    gray_frame_sequencer #(.IMG_W(160), .IMG_H(120), .ADDR_W(15), .RD_LAT(2)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .mode_sel(b_mode),
        .busy(b_busy), .done(b_done), .mem_addr(b_addr), .mem_rd_en(b_rd_en),
        .mem_rd_data(b_rd_data), .mem_wr_en(b_wr_en), .mem_wr_data(b_wr_data)
    );

    // Small buffer: 2-cycle read latency, bulk-loadable from s_init.
    logic [23:0] smem [8];
    logic [23:0] s_init [8];
    logic        s_load;
    logic [23:0] sp0, sp1;
    always @(posedge clk) begin
        if (s_load) begin
            for (int i = 0; i < 8; i++) smem[i] <= s_init[i];
        end else if (s_wr_en) begin
            smem[s_addr] <= s_wr_data;
        end
        if (s_rd_en) sp0 <= smem[s_addr];
        sp1 <= sp0;
    end
    assign s_rd_data = sp1;

    function automatic logic [23:0] bpat(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1 + 32'h01234567;
        return h[31:8];
    endfunction

    function automatic logic [23:0] lum_word(input logic [23:0] p);
        int g;
        g = (54 * int'(p[23:16]) + 183 * int'(p[15:8]) + 18 * int'(p[7:0])) / 256;
        return {3{8'(g)}};
    endfunction

    // Big buffer: unwritten words read back as bpat(addr).
    logic [23:0] bmem [19200];
    bit          bwritten [19200];
    logic [23:0] bp0, bp1;
    always @(posedge clk) begin
        if (b_wr_en) begin
            bmem[b_addr]     <= b_wr_data;
            bwritten[b_addr] <= 1'b1;
        end
        if (b_rd_en) bp0 <= bwritten[b_addr] ? bmem[b_addr] : bpat(int'(b_addr));
        bp1 <= bp0;
    end
    assign b_rd_data = bp1;

    int          cyc = 0;
    int          n_dual = 0;
    int          s_busy_cyc = 0, s_done_cnt = 0, s_wr_cnt = 0, s_wr3 = 0;
    int          b_busy_cyc = 0, b_done_cnt = 0, b_wr_cnt = 0;
    logic [14:0] b_max_addr = '0, b_last_wr = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((s_rd_en && s_wr_en) || (b_rd_en && b_wr_en)) n_dual <= n_dual + 1;
        if (s_busy) s_busy_cyc <= s_busy_cyc + 1;
        if (s_done) s_done_cnt <= s_done_cnt + 1;
        if (s_wr_en) begin
            s_wr_cnt <= s_wr_cnt + 1;
            if (s_addr == 3'd3) s_wr3 <= s_wr3 + 1;
        end
        if (b_busy) b_busy_cyc <= b_busy_cyc + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_wr_en) begin
            b_wr_cnt  <= b_wr_cnt + 1;
            b_last_wr <= b_addr;
        end
        if ((b_rd_en || b_wr_en) && (b_addr > b_max_addr)) b_max_addr <= b_addr;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input logic [23:0] v);
        for (int i = 0; i < 8; i++) s_init[i] = v;
    endtask

    task automatic pulse_load();
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
    endtask

    task automatic run_small(input logic [1:0] mode, input string tag,
                             output int t_busy, output int t_done);
        int k;
        s_mode  = mode;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(s_busy), 32'd1);
        t_busy = cyc;
        k = 0;
        while (!s_done && k < 200) begin
            tick();
            k++;
        end
        check_eq({tag, "_done_seen"}, 32'(s_done), 32'd1);
        t_done = cyc;
        tick();
    endtask

    logic [31:0] w_s_outs;
    assign w_s_outs = {2'b0, s_busy, s_done, s_rd_en, s_wr_en, s_addr, s_wr_data};

    initial begin
        int tb_, td_, k, d0, b0, w0, w30, err;

        rst_n = 1'b0;
        s_start = 0; s_abort = 0; s_mode = 0; s_load = 0;
        b_start = 0; b_abort = 0; b_mode = 0;
        load_all(24'h0);
        repeat (3) tick();
        check_eq("reset_small_outputs", w_s_outs, 32'd0);
        check_eq("reset_big_outputs", {b_busy, b_done, b_rd_en, b_wr_en, b_addr, b_wr_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a WRITE cycle
        load_all(24'h445566);
        pulse_load();
        s_mode = 2'd2; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        k = 0;
        while (!s_wr_en && k < 20) begin tick(); k++; end
        check_eq("t1_in_write", 32'(s_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t1_async_reset", w_s_outs, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("t1_idle_hold", 32'({s_busy, s_rd_en, s_wr_en}), 32'd0);

        // Luminance, done timing, busy length
        s_init[0] = 24'hFF0000; s_init[1] = 24'h00FF00; s_init[2] = 24'hFFFFFF;
        s_init[3] = 24'h0000FF; s_init[4] = 24'h000000; s_init[5] = 24'h808080;
        s_init[6] = 24'h808080; s_init[7] = 24'h808080;
        pulse_load();
        d0 = s_done_cnt; b0 = s_busy_cyc;
        run_small(2'd2, "t2", tb_, td_);
        check_eq("t2_done_latency", 32'(td_ - tb_), 32'd32);
        repeat (3) tick();
        check_eq("t2_done_pulses", 32'(s_done_cnt - d0), 32'd1);
        check_eq("t2_busy_cycles", 32'(s_busy_cyc - b0), 32'd32);
        check_eq("t2_px0_red", 32'(smem[0]), 32'h353535);
        check_eq("t2_px1_green", 32'(smem[1]), 32'hB6B6B6);
        check_eq("t2_px2_white", 32'(smem[2]), 32'hFEFEFE);
        check_eq("t2_px3_blue", 32'(smem[3]), 32'h111111);
        check_eq("t2_px4_black", 32'(smem[4]), 32'h000000);
        check_eq("t2_px7_mid", 32'(smem[7]), 32'h7F7F7F);

        // Average
        load_all(24'h102030); s_init[7] = 24'hFFFFFF;
        pulse_load();
        run_small(2'd1, "t3a", tb_, td_);
        check_eq("t3_avg_px0", 32'(smem[0]), 32'h1F1F1F);
        check_eq("t3_avg_white", 32'(smem[7]), 32'hFEFEFE);

        // Bypass and reserved mode
        load_all(24'h123456);
        pulse_load();
        w0 = s_wr_cnt;
        run_small(2'd0, "t3b", tb_, td_);
        check_eq("t3_bypass_px0", 32'(smem[0]), 32'h123456);
        check_eq("t3_bypass_writes", 32'(s_wr_cnt - w0), 32'd8);
        load_all(24'hABCDEF);
        pulse_load();
        w0 = s_wr_cnt;
        run_small(2'd3, "t3c", tb_, td_);
        check_eq("t3_reserved_px4", 32'(smem[4]), 32'hABCDEF);
        check_eq("t3_reserved_writes", 32'(s_wr_cnt - w0), 32'd8);

        // Abort during the WAIT of pixel 3
        load_all(24'hFF0000);
        pulse_load();
        d0 = s_done_cnt; w0 = s_wr_cnt; w30 = s_wr3;
        s_mode = 2'd2; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        k = 0;
        while (!(s_rd_en && s_addr == 3'd3) && k < 40) begin tick(); k++; end
        check_eq("t4_read_px3", 32'(s_rd_en && s_addr == 3'd3), 32'd1);
        tick();
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        check_eq("t4_busy_drop", 32'(s_busy), 32'd0);
        check_eq("t4_strobes_off", 32'({s_rd_en, s_wr_en}), 32'd0);
        repeat (5) tick();
        check_eq("t4_no_done", 32'(s_done_cnt - d0), 32'd0);
        check_eq("t4_no_write_px3", 32'(s_wr3 - w30), 32'd0);
        check_eq("t4_write_count", 32'(s_wr_cnt - w0), 32'd3);
        check_eq("t4_px0_conv", 32'(smem[0]), 32'h353535);
        check_eq("t4_px2_conv", 32'(smem[2]), 32'h353535);
        check_eq("t4_px3_kept", 32'(smem[3]), 32'hFF0000);
        check_eq("t4_px7_kept", 32'(smem[7]), 32'hFF0000);

        // Abort and start together in IDLE
        s_start = 1'b1; s_abort = 1'b1;
        tick();
        s_start = 1'b0; s_abort = 1'b0;
        check_eq("t4b_stay_idle", 32'({s_busy, s_rd_en}), 32'd0);

        // Start while busy and mode change mid-pass
        load_all(24'h102030);
        pulse_load();
        w0 = s_wr_cnt;
        s_mode = 2'd2; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check_eq("t5_busy_rise", 32'(s_busy), 32'd1);
        tb_ = cyc;
        repeat (5) tick();
        s_mode = 2'd1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (6) tick();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        k = 0;
        while (!s_done && k < 200) begin tick(); k++; end
        check_eq("t5_done_seen", 32'(s_done), 32'd1);
        check_eq("t5_no_restart", 32'(cyc - tb_), 32'd32);
        tick();
        err = 0;
        for (int i = 0; i < 8; i++) if (smem[i] !== 24'h1D1D1D) err++;
        check_eq("t5_latched_mode", 32'(err), 32'd0);
        check_eq("t5_write_count", 32'(s_wr_cnt - w0), 32'd8);

        // Start held high: restart one cycle after returning to IDLE
        s_mode = 2'd0; s_start = 1'b1;
        k = 0;
        while (!s_done && k < 200) begin tick(); k++; end
        check_eq("t5b_done_seen", 32'(s_done), 32'd1);
        tick();
        check_eq("t5b_idle_gap", 32'(s_busy), 32'd0);
        tick();
        check_eq("t5b_restart", 32'({s_busy, s_rd_en}), 32'd3);
        s_start = 1'b0; s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        check_eq("t5b_abort_stop", 32'(s_busy), 32'd0);

        // Full 160x120 luminance pass
        b0 = b_busy_cyc; w0 = b_wr_cnt; d0 = b_done_cnt;
        b_mode = 2'd2; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_eq("t6_busy_rise", 32'(b_busy), 32'd1);
        k = 0;
        while (!b_done && k < 80000) begin tick(); k++; end
        check_eq("t6_done_seen", 32'(b_done), 32'd1);
        repeat (2) tick();
        check_eq("t6_busy_cycles", 32'(b_busy_cyc - b0), 32'd76800);
        check_eq("t6_write_count", 32'(b_wr_cnt - w0), 32'd19200);
        check_eq("t6_done_pulses", 32'(b_done_cnt - d0), 32'd1);
        check_eq("t6_last_wr_addr", 32'(b_last_wr), 32'd19199);
        check_eq("t6_max_addr", 32'(b_max_addr), 32'd19199);
        err = 0;
        for (int a = 0; a < 19200; a++) begin
            if (!bwritten[a] || bmem[a] !== lum_word(bpat(a))) err++;
        end
        check_eq("t6_scoreboard", 32'(err), 32'd0);

        check_eq("dual_strobe", 32'(n_dual), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
